fpu_op_scheduler: RTL and testbench

Arbitrates N requesters (CPU issue slots, test harness) onto the single shared FPU op unit (4-bit opcode, 32-bit IEEE-754 operands a/b, 32-bit result c). It accepts one operation at a time, holds the operands stable on the FPU inputs for the FPU's fixed latency, captures the result, and returns it to the owning requester as a one-cycle response. Ops outside the supported mask are rejected without touching the FPU.

---
 rtl/fpu_sched_pkg.sv | 15 +
 rtl/fpu_op_scheduler_if.sv | 32 +++
 rtl/fpu_rr_arbiter.sv | 29 ++
 rtl/fpu_op_scheduler.sv | 157 +++++++++++++++
 tb/tb_fpu_op_scheduler.sv | 326 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fpu_sched_pkg.sv
// Shared types and constants for the FPU operation scheduler.
package fpu_sched_pkg;

    localparam int unsigned DATA_W = 32;

    localparam logic [3:0]        FPU_OP_ADD = 4'b0001;
    localparam logic [DATA_W-1:0] QNAN       = 32'h7FC00000;

    typedef enum logic [1:0] {
        StIdle,
        StWait,
        StResp
    } state_e;

endpackage

// File: rtl/fpu_op_scheduler_if.sv
// Requester, FPU and response signals of the scheduler, with both-side modports.
interface fpu_op_scheduler_if #(
    parameter int unsigned N_REQ = 4
);
    import fpu_sched_pkg::*;

    logic [N_REQ-1:0]        req_valid;
    logic [N_REQ-1:0]        req_ready;
    logic [4*N_REQ-1:0]      req_op;
    logic [DATA_W*N_REQ-1:0] req_a;
    logic [DATA_W*N_REQ-1:0] req_b;
    logic [3:0]              fpu_op;
    logic [DATA_W-1:0]       fpu_a;
    logic [DATA_W-1:0]       fpu_b;
    logic [DATA_W-1:0]       fpu_c;
    logic [N_REQ-1:0]        rsp_valid;
    logic [DATA_W-1:0]       rsp_data;
    logic                    rsp_err;
    logic                    busy;

    modport slave (
        input  req_valid, req_op, req_a, req_b, fpu_c,
        output req_ready, fpu_op, fpu_a, fpu_b, rsp_valid, rsp_data, rsp_err, busy
    );

    // Requesters and the FPU itself, as seen by whoever drives them.
    modport master (
        output req_valid, req_op, req_a, req_b, fpu_c,
        input  req_ready, fpu_op, fpu_a, fpu_b, rsp_valid, rsp_data, rsp_err, busy
    );

endinterface

// File: rtl/fpu_rr_arbiter.sv
// Round-robin arbiter: one-hot grant to the first request at or after ptr, wrapping.
module fpu_rr_arbiter #(
    parameter  int unsigned N_REQ = 4,
    localparam int unsigned ID_W  = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [ID_W-1:0]  ptr,
    output logic [N_REQ-1:0] gnt,
    output logic [ID_W-1:0]  id
);

    logic [ID_W-1:0] sel;

    // Walk offsets from farthest to nearest so the nearest valid request wins.
    always_comb begin
        gnt = '0;
        id  = '0;
        sel = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            sel = ID_W'((32'(ptr) + 32'(i)) % N_REQ);
            if (req[sel]) begin
                gnt      = '0;
                gnt[sel] = 1'b1;
                id       = sel;
            end
        end
    end

endmodule

// File: rtl/fpu_op_scheduler.sv
// Arbitrates N_REQ requesters onto one fixed-latency FPU and returns one-cycle responses.
// Build option FPU_SCHED_FIXED_PRIO_EN: fixed priority (lowest index wins) instead of round-robin.
module fpu_op_scheduler
    import fpu_sched_pkg::*;
#(
    parameter int unsigned N_REQ   = 4,
    parameter int unsigned FPU_LAT = 4,
    parameter logic [15:0] OP_MASK = 16'h0002
) (
    input logic               i_clk,
    input logic               i_reset,
    fpu_op_scheduler_if.slave bus
);

    localparam int unsigned ID_W  = $clog2(N_REQ);
    localparam int unsigned CNT_W = $clog2(FPU_LAT + 1);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [3:0]        op_q, op_d;
    logic [DATA_W-1:0] a_q, a_d, b_q, b_d;
    logic [ID_W-1:0]   id_q, id_d;
    logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
    logic              rsp_err_q, rsp_err_d;

    logic [ID_W-1:0]   ptr;
    logic [ID_W-1:0]   gnt_id;
    logic [N_REQ-1:0]  gnt;
    logic              hs;
    logic [3:0]        sel_op;
    logic [DATA_W-1:0] sel_a, sel_b;

    fpu_rr_arbiter #(
        .N_REQ (N_REQ)
    ) u_arb (
        .req (bus.req_valid),
        .ptr (ptr),
        .gnt (gnt),
        .id  (gnt_id)
    );

    assign hs = (state_q == StIdle) && (|gnt);

`ifdef FPU_SCHED_FIXED_PRIO_EN
    assign ptr = '0;
`else
    logic [ID_W-1:0] rr_q, rr_d;

    assign rr_d = !hs ? rr_q : (gnt_id == ID_W'(N_REQ - 1)) ? '0 : gnt_id + 1'b1;
    assign ptr  = rr_q;

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) rr_q <= '0;
        else          rr_q <= rr_d;
    end
`endif

    always_comb begin
        sel_op = '0;
        sel_a  = '0;
        sel_b  = '0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            if (gnt_id == ID_W'(k)) begin
                sel_op = bus.req_op[4*k +: 4];
                sel_a  = bus.req_a[DATA_W*k +: DATA_W];
                sel_b  = bus.req_b[DATA_W*k +: DATA_W];
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        op_d       = op_q;
        a_d        = a_q;
        b_d        = b_q;
        id_d       = id_q;
        rsp_data_d = rsp_data_q;
        rsp_err_d  = rsp_err_q;
        unique case (state_q)
            StIdle: begin
                if (hs) begin
                    op_d  = sel_op;
                    a_d   = sel_a;
                    b_d   = sel_b;
                    id_d  = gnt_id;
                    cnt_d = '0;
                    // Unsupported ops skip the FPU entirely.
                    if (OP_MASK[sel_op]) begin
                        state_d   = StWait;
                        rsp_err_d = 1'b0;
                    end else begin
                        state_d    = StResp;
                        rsp_data_d = QNAN;
                        rsp_err_d  = 1'b1;
                    end
                end
            end
            StWait: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(FPU_LAT - 1)) begin
                    rsp_data_d = bus.fpu_c;
                    rsp_err_d  = 1'b0;
                    state_d    = StResp;
                end
            end
            StResp:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            op_q       <= '0;
            a_q        <= '0;
            b_q        <= '0;
            id_q       <= '0;
            rsp_data_q <= '0;
            rsp_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            op_q       <= op_d;
            a_q        <= a_d;
            b_q        <= b_d;
            id_q       <= id_d;
            rsp_data_q <= rsp_data_d;
            rsp_err_q  <= rsp_err_d;
        end
    end

    // Ready is gated by reset so nothing looks accepted while reset is held.
    always_comb begin
        bus.req_ready = '0;
        bus.fpu_op    = '0;
        bus.fpu_a     = '0;
        bus.fpu_b     = '0;
        bus.rsp_valid = '0;
        bus.rsp_err   = 1'b0;
        if (state_q == StIdle && i_reset) bus.req_ready = gnt;
        if (state_q == StWait) begin
            bus.fpu_op = op_q;
            bus.fpu_a  = a_q;
            bus.fpu_b  = b_q;
        end
        if (state_q == StResp) begin
            bus.rsp_valid[id_q] = 1'b1;
            bus.rsp_err         = rsp_err_q;
        end
    end

    assign bus.rsp_data = rsp_data_q;
    assign bus.busy     = (state_q != StIdle);

endmodule

// File: tb/tb_fpu_op_scheduler.sv
// Scoreboard bench for fpu_op_scheduler with a 4-cycle pipelined FPU model.
module tb_fpu_op_scheduler;
    import fpu_sched_pkg::*;

    localparam int unsigned N_REQ   = 4;
    localparam int unsigned FPU_LAT = 4;
    localparam logic [15:0] TB_MASK = 16'h0002;

    typedef struct {
        int          id;
        logic [31:0] data;
        logic        err;
        int          due;
    } exp_t;

    logic i_clk   = 1'b0;
    logic i_reset = 1'b0;
    logic mon_en  = 1'b0;
    int   n_vec   = 0;
    int   n_err   = 0;
    int   cyc     = 0;

    exp_t exp_q[$];
    int   gnt_log[$];
    int   hs_cyc[$];
    logic [31:0] last_rsp_data = '0;

    logic        rq_valid[N_REQ];
    logic [3:0]  rq_op[N_REQ];
    logic [31:0] rq_a[N_REQ];
    logic [31:0] rq_b[N_REQ];

    logic [31:0] s1 = '0, s2 = '0, s3 = '0;

    logic        act_valid = 1'b0;
    logic        act_err   = 1'b0;
    int          act_hk    = 0;
    logic [3:0]  act_op    = '0;
    logic [31:0] act_a     = '0;
    logic [31:0] act_b     = '0;

    fpu_op_scheduler_if #(.N_REQ(N_REQ)) bus ();

    fpu_op_scheduler #(
        .N_REQ   (N_REQ),
        .FPU_LAT (FPU_LAT),
        .OP_MASK (TB_MASK)
    ) dut (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .bus     (bus)
    );

    always #5 i_clk = ~i_clk;

    for (genvar k = 0; k < N_REQ; k++) begin : g_drv
        assign bus.req_valid[k]       = rq_valid[k];
        assign bus.req_op[4*k +: 4]   = rq_op[k];
        assign bus.req_a[32*k +: 32]  = rq_a[k];
        assign bus.req_b[32*k +: 32]  = rq_b[k];
    end

    // Stand-in FPU: known float adds from a table, otherwise a fixed bit mix.
    function automatic logic [31:0] fpu_fn(input logic [3:0] op, input logic [31:0] a,
                                           input logic [31:0] b);
        if (op == FPU_OP_ADD) begin
            case ({a, b})
                {32'h40000000, 32'h3F800000}: return 32'h40400000;
                {32'h3F800000, 32'h3F800000}: return 32'h40000000;
                {32'h40000000, 32'h40000000}: return 32'h40800000;
                default:                      return a ^ {b[15:0], b[31:16]};
            endcase
        end
        return a ^ b ^ {28'h0, op};
    endfunction

    // Three register stages: result is valid on the 4th edge after operands appear.
    always @(posedge i_clk) begin
        s1 <= fpu_fn(bus.fpu_op, bus.fpu_a, bus.fpu_b);
        s2 <= s1;
        s3 <= s2;
    end
    assign bus.fpu_c = s3;

    always @(posedge i_clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [95:0] obs, input logic [95:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    always @(negedge i_clk) begin : mon
        logic [N_REQ-1:0] hs;
        logic [N_REQ-1:0] oh;
        logic             in_busy;
        logic             in_wait;
        logic             err;
        int               id;
        exp_t             e;
        if (mon_en) begin
            in_busy = act_valid && (cyc >= act_hk + 1) &&
                      (cyc <= act_hk + 1 + (act_err ? 0 : int'(FPU_LAT)));
            in_wait = act_valid && !act_err && (cyc >= act_hk + 1) &&
                      (cyc <= act_hk + int'(FPU_LAT));
            check_eq("busy", 96'(bus.busy), 96'(in_busy));
            check_eq("fpu_in", 96'({bus.fpu_op, bus.fpu_a, bus.fpu_b}),
                     in_wait ? 96'({act_op, act_a, act_b}) : 96'(0));

            if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
                e  = exp_q.pop_front();
                oh = N_REQ'(1) << e.id;
                check_eq("rsp_valid", 96'(bus.rsp_valid), 96'(oh));
                check_eq("rsp_data", 96'(bus.rsp_data), 96'(e.data));
                check_eq("rsp_err", 96'(bus.rsp_err), 96'(e.err));
                last_rsp_data = bus.rsp_data;
            end else begin
                check_eq("rsp_idle", 96'({bus.rsp_valid, bus.rsp_err}), 96'(0));
            end

            hs = bus.req_valid & bus.req_ready;
            if (hs != '0) begin
                check_eq("ready_onehot", 96'($onehot(hs)), 96'(1));
                id = 0;
                for (int j = 0; j < N_REQ; j++) if (hs[j]) id = j;
                err       = !TB_MASK[rq_op[id]];
                act_valid = 1'b1;
                act_err   = err;
                act_hk    = cyc;
                act_op    = rq_op[id];
                act_a     = rq_a[id];
                act_b     = rq_b[id];
                gnt_log.push_back(id);
                hs_cyc.push_back(cyc);
                exp_q.push_back('{id, err ? QNAN : fpu_fn(rq_op[id], rq_a[id], rq_b[id]), err,
                                  cyc + (err ? 1 : int'(FPU_LAT) + 1)});
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge i_clk);
        #1;
    endtask

    task automatic do_reset();
        tick(1);
        i_reset = 1'b0;
        exp_q.delete();
        act_valid = 1'b0;
        tick(2);
        i_reset = 1'b1;
    endtask

    task automatic issue(input int k, input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] b);
        int t;
        t           = 0;
        rq_valid[k] = 1'b1;
        rq_op[k]    = op;
        rq_a[k]     = a;
        rq_b[k]     = b;
        @(negedge i_clk);
        while (!(bus.req_valid[k] && bus.req_ready[k]) && t < 50) begin
            @(negedge i_clk);
            t++;
        end
        check_eq("issue_wait", 96'(t < 50), 96'(1));
        tick(1);
        rq_valid[k] = 1'b0;
    endtask

    task automatic wait_grants(input int n);
        int t;
        t = 0;
        while (gnt_log.size() < n && t < 200) begin
            @(negedge i_clk);
            t++;
        end
        check_eq("grant_wait", 96'(t < 200), 96'(1));
        tick(1);
    endtask

    task automatic wait_idle();
        int t;
        t = 0;
        @(negedge i_clk);
        while ((exp_q.size() != 0 || bus.busy) && t < 100) begin
            @(negedge i_clk);
            t++;
        end
        check_eq("idle_wait", 96'(t < 100), 96'(1));
        tick(1);
    endtask

    task automatic check_log(input string tag, input int exp_ids[]);
        check_eq({tag, "_cnt"}, 96'(gnt_log.size()), 96'(exp_ids.size()));
        for (int i = 0; i < exp_ids.size(); i++)
            check_eq(tag, 96'(i < gnt_log.size() ? gnt_log[i] : -1), 96'(exp_ids[i]));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int ids[];
        for (int k = 0; k < N_REQ; k++) begin
            rq_valid[k] = 1'b0;
            rq_op[k]    = '0;
            rq_a[k]     = '0;
            rq_b[k]     = '0;
        end
        // Reset held from time 0: a valid request must not see ready.
        rq_valid[0] = 1'b1;
        rq_op[0]    = FPU_OP_ADD;
        #12;
        check_eq("rst_ready", 96'(bus.req_ready), 96'(0));
        check_eq("rst_busy", 96'(bus.busy), 96'(0));
        check_eq("rst_rsp", 96'({bus.rsp_valid, bus.rsp_err, bus.rsp_data}), 96'(0));
        check_eq("rst_fpu", 96'({bus.fpu_op, bus.fpu_a, bus.fpu_b}), 96'(0));
        rq_valid[0] = 1'b0;
        tick(1);
        i_reset = 1'b1;
        mon_en  = 1'b1;
        tick(2);

        // Single add, 2.0 + 1.0
        gnt_log.delete();
        issue(0, FPU_OP_ADD, 32'h40000000, 32'h3F800000);
        wait_idle();
        check_eq("add_result", 96'(last_rsp_data), 96'(32'h40400000));
        check_eq("rsp_data_hold", 96'(bus.rsp_data), 96'(32'h40400000));

        // Unsupported opcode goes straight to an error response
        issue(2, 4'b0011, 32'h12345678, 32'h9ABCDEF0);
        wait_idle();
        check_eq("err_result", 96'(last_rsp_data), 96'(32'h7FC00000));

`ifndef FPU_SCHED_FIXED_PRIO_EN
        // All four requesters continuously valid
        do_reset();
        gnt_log.delete();
        hs_cyc.delete();
        for (int k = 0; k < N_REQ; k++) begin
            rq_valid[k] = 1'b1;
            rq_op[k]    = FPU_OP_ADD;
            rq_a[k]     = 32'h3F800000 + 32'(k);
            rq_b[k]     = 32'h40000000 - 32'(k * 3);
        end
        wait_grants(5);
        for (int k = 0; k < N_REQ; k++) rq_valid[k] = 1'b0;
        wait_idle();
        ids = '{0, 1, 2, 3, 0};
        check_log("rr_order", ids);
        for (int i = 1; i < 5; i++)
            check_eq("rr_interval", 96'(i < hs_cyc.size() ? hs_cyc[i] - hs_cyc[i-1] : -1),
                     96'(FPU_LAT + 2));

        // Pointer wraps back past requester 3
        do_reset();
        gnt_log.delete();
        issue(3, FPU_OP_ADD, 32'h3F800000, 32'h3F800000);
        wait_idle();
        rq_valid[0] = 1'b1;
        rq_op[0]    = FPU_OP_ADD;
        rq_a[0]     = 32'h40000000;
        rq_b[0]     = 32'h40000000;
        rq_valid[3] = 1'b1;
        rq_a[3]     = 32'h00C0FFEE;
        wait_grants(3);
        rq_valid[0] = 1'b0;
        rq_valid[3] = 1'b0;
        wait_idle();
        ids = '{3, 0, 3};
        check_log("rr_wrap", ids);
`else
        // Fixed priority: requester 0 wins until it drops
        do_reset();
        gnt_log.delete();
        for (int k = 0; k < 2; k++) begin
            rq_valid[k] = 1'b1;
            rq_op[k]    = FPU_OP_ADD;
            rq_a[k]     = 32'h11110000 + 32'(k);
            rq_b[k]     = 32'h00002222;
        end
        wait_grants(3);
        rq_valid[0] = 1'b0;
        wait_grants(4);
        rq_valid[1] = 1'b0;
        wait_idle();
        ids = '{0, 0, 0, 1};
        check_log("fixed_prio", ids);
`endif

        // Reset in the middle of an FPU wait discards the op
        issue(1, FPU_OP_ADD, 32'h3F800000, 32'h3F800000);
        tick(1);
        rq_valid[2] = 1'b1;
        rq_op[2]    = FPU_OP_ADD;
        i_reset     = 1'b0;
        exp_q.delete();
        act_valid   = 1'b0;
        #1;
        check_eq("rstw_busy", 96'(bus.busy), 96'(0));
        check_eq("rstw_ready", 96'(bus.req_ready), 96'(0));
        check_eq("rstw_rsp", 96'({bus.rsp_valid, bus.rsp_err}), 96'(0));
        check_eq("rstw_fpu", 96'({bus.fpu_op, bus.fpu_a, bus.fpu_b}), 96'(0));
        rq_valid[2] = 1'b0;
        tick(2);
        i_reset = 1'b1;
        tick(8);
        issue(1, FPU_OP_ADD, 32'h40000000, 32'h40000000);
        wait_idle();
        check_eq("post_rst_add", 96'(last_rsp_data), 96'(32'h40800000));

        check_eq("sb_empty", 96'(exp_q.size()), 96'(0));
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
